uart_tx_core: RTL and testbench

//  - UART 8N1 transmitter: serialises one byte per start pulse onto o_tx.
//  - Includes its own baud/oversample tick generation.
//  - Sits directly downstream of the ASCII sender FSM, inside the UART top.
//  - Consumes the 1-cycle start pulse and data byte; returns a busy-level status (o_tx_done).

---
 rtl/uart_tx_core_pkg.sv | 31 +++
 rtl/uart_tx_core_baud_tick.sv | 45 ++++
 rtl/uart_tx_core.sv | 134 +++++++++++++
 tb/tb_uart_tx_core.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_tx_core_pkg.sv
// Purpose : shared UART definitions -- TX FSM state encoding, default line
//           parameters (reused by the UART receiver) and the divider helper.
// Contents: tx_state_e, DEFAULT_* constants, calc_div().
package uart_tx_core_pkg;

    // Transmitter FSM state encoding (2 bits).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DEFAULT_CLK_FREQ   = 100_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE  = 9600;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS          = 8;

    // Clocks per oversample tick, truncated; never below 1 so the divider is valid.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned div;
        div = clk_freq / (baud_rate * oversample);
        if (div == 0) begin
            div = 1;
        end
        return div;
    endfunction

endpackage : uart_tx_core_pkg

// File: rtl/uart_tx_core_baud_tick.sv
// Purpose : oversample tick generator; emits a 1-cycle o_tick every DIV clocks.
// Ports   : clk, rst (async, active-high)
//           i_clr  - synchronous clear; restarts the DIV period from zero
//           o_tick - registered 1-cycle tick, high in the last clock of each period
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count; the tick is registered from the next count so it is high
    // exactly while the counter holds DIV-1 (last clock of the period).
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_W'(DIV - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule : uart_baud_tick

// File: rtl/uart_tx_core.sv
// Purpose : UART 8N1 transmitter. One byte per accepted i_start pulse is sent
//           LSB first as start(0), 8 data bits, stop(1), OVERSAMPLE ticks per bit.
// Ports   : clk, rst (async, active-high)
//           i_start   - request, only honoured in IDLE
//           i_tx_data - byte captured in the cycle i_start is accepted
//           o_tx_done - registered busy level, high for the whole frame
//           o_tx      - registered serial line, idle high
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_tx
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    tx_state_e               state_q, state_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;

    logic                    tick;
    logic                    clr_c;
    logic                    tick_last_c;

    // Accepting a request realigns the baud divider to the frame start.
    assign clr_c       = (state_q == ST_IDLE) && i_start;
    assign tick_last_c = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (clr_c),
        .o_tick (tick)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tick_cnt_d = tick_cnt_q;
        tx_d       = tx_q;
        done_d     = done_q;

        // Ticks within the current bit; wraps at the end of every bit.
        if (state_q != ST_IDLE && tick) begin
            tick_cnt_d = tick_last_c ? '0 : tick_cnt_q + TICK_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                done_d = 1'b0;
                if (i_start) begin
                    state_d    = ST_START;
                    shift_d    = i_tx_data;
                    bit_idx_d  = '0;
                    tick_cnt_d = '0;
                    tx_d       = 1'b0;
                    done_d     = 1'b1;
                end
            end
            ST_START: begin
                if (tick_last_c) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick_last_c) begin
                    if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift right so shift_q[0] is always the bit on the line.
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick_last_c) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tick_cnt_q <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tick_cnt_q <= tick_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = done_q;

endmodule : uart_tx_core

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core at DIV=10 (160 clk/bit, 1600 clk/frame).
// The expected line is derived from the 8N1 frame rule: bit slot k = t/160
// carries start(0), data[k-1], or stop(1).
module tb_uart_tx_core;

    localparam int unsigned BIT_CLKS   = 160;
    localparam int unsigned FRAME_CLKS = 1600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_tx_data = 8'h00;
    logic       o_tx_done;
    logic       o_tx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_core #(
        .CLK_FREQ   (16_000),
        .BAUD_RATE  (100),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_tx_data (i_tx_data),
        .o_tx_done (o_tx_done),
        .o_tx      (o_tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: value of the line in bit slot k of a frame carrying byte d.
    function automatic logic line_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return d[k-1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq($sformatf("%s tx", tag), 32'(o_tx), 32'd1);
        check_eq($sformatf("%s done", tag), 32'(o_tx_done), 32'd0);
    endtask

    // Sends one frame and checks it. hold: extra cycles i_start stays high;
    // inj_t: cycle of an extra (ignored) start with inj_d; rst_t: cycle of reset abort.
    task automatic send_frame(input logic [7:0] d, input int hold, input int inj_t,
                              input logic [7:0] inj_d, input int rst_t, input string name);
        i_start   = 1'b1;
        i_tx_data = d;
        step();
        for (int t = 0; t <= int'(FRAME_CLKS); t++) begin
            int k;
            int ph;
            k  = t / int'(BIT_CLKS);
            ph = t % int'(BIT_CLKS);
            if (t == int'(FRAME_CLKS)) begin
                check_idle($sformatf("%s end t=%0d", name, t));
            end else if (ph == 0 || ph == 80 || ph == 159) begin
                check_eq($sformatf("%s tx t=%0d", name, t), 32'(o_tx), 32'(line_bit(d, k)));
                check_eq($sformatf("%s done t=%0d", name, t), 32'(o_tx_done), 32'd1);
            end
            i_start   = (t < hold) || (t == inj_t);
            i_tx_data = (t == inj_t) ? inj_d : 8'($urandom);
            if (t == rst_t) begin
                i_start = 1'b0;
                rst     = 1'b1;
                #1;
                check_idle($sformatf("%s abort", name));
                repeat (3) step();
                check_idle($sformatf("%s in_rst", name));
                rst = 1'b0;
                return;
            end
            if (t < int'(FRAME_CLKS)) step();
        end
        i_start = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        i_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check_idle($sformatf("%s c=%0d", tag, i));
        end
    endtask

    initial begin
        // 1. reset held 5 clk, then 50 idle clocks
        rst = 1'b1;
        repeat (5) step();
        check_idle("rst_held");
        rst = 1'b0;
        idle_cycles(50, "post_rst");

        // 2. single frame 0x30
        send_frame(8'h30, 0, -1, 8'h00, -1, "f30");
        idle_cycles(5, "gap2");

        // 3. ignored start with 0xFF at clk 500 of a 0x00 frame
        send_frame(8'h00, 0, 500, 8'hFF, -1, "f00_inj");
        idle_cycles(3, "gap3");

        // 4. back-to-back 0x7A then 0x30 with a single idle-high clock
        send_frame(8'h7A, 0, -1, 8'h00, -1, "b2b_7a");
        send_frame(8'h30, 0, -1, 8'h00, -1, "b2b_30");
        idle_cycles(3, "gap4");

        // held start starts only one frame
        send_frame(8'($urandom), 4, -1, 8'h00, -1, "hold");
        idle_cycles(3, "gap_hold");

        // 5. reset mid-DATA, then a clean 0x55 frame
        send_frame(8'($urandom), 0, -1, 8'h00, 700, "abort");
        idle_cycles(5, "post_abort");
        send_frame(8'h55, 0, -1, 8'h00, -1, "f55");
        idle_cycles(2, "gap5");

        // 6. boundary bytes
        send_frame(8'h00, 0, -1, 8'h00, -1, "f00");
        send_frame(8'hFF, 0, -1, 8'h00, -1, "fff");

        // randomized frames with random gaps (0 = back-to-back)
        for (int n = 0; n < 4; n++) begin
            send_frame(8'($urandom), 0, -1, 8'h00, -1, $sformatf("rnd%0d", n));
            idle_cycles(int'($urandom_range(0, 4)), $sformatf("rgap%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_core
